// File: rtl/prism_cfg_seq_if.sv
// Bundles the host-side queue/start/abort controls, the direct host write path,
// the PRISM debug port and the sequencer status signals.
interface prism_cfg_seq_if #(
    parameter int DEPTH = 8
);
    logic                     q_push;
    logic [5:0]               q_addr;
    logic [31:0]              q_data;
    logic                     start;
    logic                     auto_en;
    logic                     abort;
    logic                     host_wr;
    logic [5:0]               host_addr;
    logic [31:0]              host_wdata;
    logic                     dbg_wr;
    logic [5:0]               dbg_addr;
    logic [31:0]              dbg_wdata;
    logic                     dbg_reset;
    logic                     fsm_enable;
    logic                     busy;
    logic                     done;
    logic [$clog2(DEPTH):0]   q_count;
    logic                     q_full;
    logic                     overflow;

    modport master (
        output q_push, q_addr, q_data, start, auto_en, abort,
               host_wr, host_addr, host_wdata,
        input  dbg_wr, dbg_addr, dbg_wdata, dbg_reset, fsm_enable,
               busy, done, q_count, q_full, overflow
    );

    modport slave (
        input  q_push, q_addr, q_data, start, auto_en, abort,
               host_wr, host_addr, host_wdata,
        output dbg_wr, dbg_addr, dbg_wdata, dbg_reset, fsm_enable,
               busy, done, q_count, q_full, overflow
    );
endinterface

// File: rtl/prism_cfg_seq.sv
// PRISM configuration sequencer: queues debug writes, then halts PRISM, drains
// the queue onto the debug port, releases reset and optionally re-enables the FSM.
//
// state   | meaning
// IDLE    | waiting for start; host writes pass straight through
// HALT    | dbg_reset held, settling before the first queued write
// WRITE   | draining the FIFO onto the debug port (host writes stall it)
// RELEASE | last cycle with dbg_reset asserted
// FIN     | done pulse; fsm_enable takes the latched auto_en
module prism_cfg_seq #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    prism_cfg_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WRITE,
        S_RELEASE,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [37:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [SW-1:0]  settle_q;
    logic           dbg_reset_q, fsm_enable_q, auto_q, overflow_q;
    logic           empty, full, push_ok, pop, seq_wr, done, start_ok;
    logic [37:0]    head;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign push_ok  = bus.q_push && !full && !bus.abort;
    assign pop      = seq_wr && !bus.abort;
    assign start_ok = (state_q == S_IDLE) && bus.start && !bus.abort;
    assign head     = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= {bus.q_addr, bus.q_data};
    end

    // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Emptiness is checked as the queue drains so the last write leads straight into RELEASE.
    always_comb begin
        state_d = state_q;
        seq_wr  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_HALT;
            end
            S_HALT: begin
                if (settle_q == SETTLE_LAST) state_d = empty ? S_RELEASE : S_WRITE;
            end
            S_WRITE: begin
                if (empty) begin
                    state_d = S_RELEASE;
                end else if (!bus.host_wr) begin
                    seq_wr = 1'b1;
                    if (count_q == CW'(1) && !push_ok) state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_FIN;
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_reset_q  <= 1'b0;
            fsm_enable_q <= 1'b0;
            auto_q       <= 1'b0;
            settle_q     <= '0;
        end else if (bus.abort) begin
            dbg_reset_q  <= 1'b0;
            fsm_enable_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        dbg_reset_q  <= 1'b1;
                        fsm_enable_q <= 1'b0;
                        auto_q       <= bus.auto_en;
                        settle_q     <= '0;
                    end
                end
                S_HALT:    settle_q     <= settle_q + SW'(1);
                S_RELEASE: dbg_reset_q  <= 1'b0;
                S_FIN:     fsm_enable_q <= auto_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  overflow_q <= 1'b0;
        else if (start_ok)                           overflow_q <= 1'b0;
        else if (bus.q_push && full && !bus.abort)   overflow_q <= 1'b1;
    end

    assign bus.dbg_wr     = bus.host_wr | seq_wr;
    assign bus.dbg_addr   = bus.host_wr ? bus.host_addr  : head[37:32];
    assign bus.dbg_wdata  = bus.host_wr ? bus.host_wdata : head[31:0];
    assign bus.dbg_reset  = dbg_reset_q;
    assign bus.fsm_enable = fsm_enable_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done;
    assign bus.q_count    = count_q;
    assign bus.q_full     = full;
    assign bus.overflow   = overflow_q;
endmodule

// File: doc/prism_cfg_seq.md
Name: prism_cfg_seq

Overview:
- Configuration sequencer for the PRISM state-machine controller.
- The host queues (address, data) configuration writes into a small FIFO, then issues start.
- The block then runs the full sequence autonomously: hold PRISM in debug reset with the FSM disabled, drain the queue onto the PRISM debug write port, release reset, optionally re-enable the FSM.
- It sits between the TinyQV peripheral register decode and the PRISM debug port, and arbitrates that port with direct host writes (host has priority).

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2).
- SETTLE, 2, cycles held in HALT before the first write (>=1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- q_push  input  1  push {q_addr,q_data} into FIFO
- q_addr  input  6  queued debug address
- q_data  input  32  queued debug write data
- start  input  1  begin sequence (single-cycle pulse)
- auto_en  input  1  sampled at start; 1 = set fsm_enable at end of sequence
- abort  input  1  cancel sequence and flush FIFO
- host_wr  input  1  direct host write to PRISM debug port
- host_addr  input  6  direct host address
- host_wdata  input  32  direct host data
- dbg_wr  output  1  PRISM debug write strobe
- dbg_addr  output  6  PRISM debug address
- dbg_wdata  output  32  PRISM debug write data
- dbg_reset  output  1  PRISM debug reset (registered)
- fsm_enable  output  1  PRISM FSM enable (registered)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse on sequence completion
- q_count  output  $clog2(DEPTH)+1  FIFO occupancy
- q_full  output  1  q_count == DEPTH
- overflow  output  1  sticky; a push was attempted while full

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- Reset values:
  - state IDLE; FIFO empty, so q_count=0 and q_full=0.
  - dbg_reset=0, fsm_enable=0, done=0, overflow=0, busy=0, dbg_wr=0.
  - Internal auto_en latch=0.
- FIFO:
  - Push accepted whenever not full, in any state; pushes during WRITE are drained in the same sequence.
  - Push while full is dropped and sets overflow.
  - Simultaneous push and pop leaves q_count unchanged.
  - Pointers wrap modulo DEPTH.
- States: IDLE, HALT, WRITE, RELEASE, FIN.
- IDLE:
  - start=1 (and abort=0): latch auto_en, clear overflow, go to HALT.
  - Next edge: dbg_reset<=1, fsm_enable<=0, settle counter<=0.
- HALT:
  - Counter increments each cycle; after SETTLE cycles in HALT, go to WRITE.
- WRITE:
  - Each cycle with FIFO non-empty and host_wr=0: sequencer write is active, the head entry drives dbg_addr/dbg_wdata with dbg_wr=1, and the entry is popped at the clock edge.
  - With host_wr=1: no pop that cycle (stall).
  - FIFO empty at the start of a WRITE cycle: go to RELEASE (an empty queue gives zero write cycles).
- RELEASE:
  - dbg_reset<=0; go to FIN.
- FIN:
  - done=1 for exactly this cycle.
  - fsm_enable<=latched auto_en.
  - Next state IDLE.
- Debug port mux (combinational):
  - host_wr=1: dbg_wr=1 with host_addr/host_wdata, in every state.
  - Else: sequencer write as defined in WRITE.
  - Else: dbg_wr=0, and addr/data hold the FIFO head (don't-care).
- start while busy: ignored.
- abort (any state, highest priority over start):
  - Next edge: state IDLE, FIFO flushed, dbg_reset<=0, fsm_enable<=0, no done pulse.
  - overflow is not cleared.
  - Push in the same cycle as abort is discarded.
- Host writes during IDLE: pass straight through and do not touch the FIFO.
- fsm_enable and dbg_reset change only on sequencer transitions or abort; they hold otherwise.

Test Plan:
- Basic sequence:
  - Stimulus: push 3 entries (0x04/0x11111111, 0x08/0x22222222, 0x0C/0x33333333); start with auto_en=1; SETTLE=2.
  - Required: dbg_reset high from cycle 1; dbg_wr on cycles 3,4,5 with the entries in order; dbg_reset low at cycle 7; done pulse at cycle 7; fsm_enable=1 from cycle 8; q_count=0.
- Host contention:
  - Stimulus: same as the basic sequence, with host_wr=1 (addr 0x10, data 0xDEADBEEF) on the first WRITE cycle.
  - Required: port shows the host write that cycle; queued writes follow on the next 3 cycles; done pulse delayed by 1 cycle.
- Full/overflow:
  - Stimulus: push 9 entries with DEPTH=8.
  - Required: q_full=1, q_count=8, overflow=1; start clears overflow; exactly 8 dbg_wr pulses follow.
- Empty queue:
  - Stimulus: start with auto_en=0 and empty FIFO.
  - Required: HALT for 2 cycles, then RELEASE, done pulse; no dbg_wr; fsm_enable=0.
- Abort mid-WRITE:
  - Stimulus: abort after 1 of 4 writes.
  - Required: next cycle IDLE, q_count=0, dbg_reset=0, fsm_enable=0, no done pulse; a subsequent start runs normally.
- Reset and ignored start:
  - Stimulus: assert rst_n=0 asynchronously mid-HALT.
  - Required: outputs immediately at reset values.
  - Stimulus: start pulse during WRITE.
  - Required: ignored; sequence completes once.
